bin2bcd_seq: RTL



---
 rtl/bin2bcd_pkg.sv | 23 ++
 rtl/bin2bcd_seq_if.sv | 30 +++
 rtl/bin2bcd_seq_digit_adj.sv | 10 +
 rtl/bin2bcd_seq.sv | 100 ++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared types, constants and helpers for the sequential binary-to-BCD converter
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'h9;
    localparam logic [3:0] ADJ_THRESH    = 4'd5;

    // Largest value representable in the given number of decimal digits (10^digits - 1).
    function automatic logic [63:0] max_bcd_value(input int digits);
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < digits; i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - request/result bundle between a converter client and bin2bcd_seq
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
);
    logic [BIN_W-1:0]    bin_in;
    logic                start;
    logic                busy;
    logic                done;
    logic                ovf;
    logic [4*DIGITS-1:0] bcd_out;

    modport master (
        output bin_in,
        output start,
        input  busy,
        input  done,
        input  ovf,
        input  bcd_out
    );

    modport slave (
        input  bin_in,
        input  start,
        output busy,
        output done,
        output ovf,
        output bcd_out
    );
endinterface

// File: rtl/bin2bcd_seq_digit_adj.sv
// rtl/bin2bcd_seq_digit_adj.sv - per-digit double-dabble correction: add 3 when the digit is 5 or more
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);
    // Max input reaching here is 9, so the sum tops out at 4'hC and cannot wrap.
    assign o_digit = (i_digit >= ADJ_THRESH) ? (i_digit + 4'd3) : i_digit;
endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - one-bit-per-clock double-dabble converter; BIN2BCD_SAT_EN saturates overflowed results to all 9s
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
) (
    input  logic clk,
    input  logic rst_n,
    bin2bcd_seq_if.slave bus
);
    localparam int          WORK_W  = 4 * DIGITS;
    localparam int          CNT_W   = $clog2(BIN_W + 1);
    localparam logic [63:0] MAX_VAL = max_bcd_value(DIGITS);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BIN_W-1:0]    r_bin;
    logic [WORK_W-1:0]   r_work;
    logic [WORK_W-1:0]   w_adj;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ovf_pend;
    logic [WORK_W-1:0]   r_bcd_out;
    logic                r_ovf;
    logic                r_done;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .i_digit (r_work[4*g +: 4]),
                .o_digit (w_adj[4*g +: 4])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = SHIFT;
            SHIFT:   if (r_cnt == CNT_W'(BIN_W - 1)) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin      <= '0;
            r_work     <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_bcd_out  <= '0;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_bin      <= bus.bin_in;
                        r_work     <= '0;
                        r_cnt      <= '0;
                        r_ovf_pend <= (64'(bus.bin_in) > MAX_VAL);
                    end
                end
                SHIFT: begin
                    // Carry out of the top digit is dropped, so the raw result wraps modulo 10^DIGITS.
                    r_work <= {w_adj[WORK_W-2:0], r_bin[BIN_W-1]};
                    r_bin  <= {r_bin[BIN_W-2:0], 1'b0};
                    r_cnt  <= r_cnt + CNT_W'(1);
                end
                DONE: begin
`ifdef BIN2BCD_SAT_EN
                    r_bcd_out <= r_ovf_pend ? {DIGITS{BCD_MAX_DIGIT}} : r_work;
`else
                    r_bcd_out <= r_work;
`endif
                    r_ovf  <= r_ovf_pend;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (r_state != IDLE);
    assign bus.done    = r_done;
    assign bus.ovf     = r_ovf;
    assign bus.bcd_out = r_bcd_out;

endmodule
